mux_7seg_scan: RTL

//  Downstream stage of the counter/7-seg decoder chain: takes N_DIGITS 8-bit

---
 rtl/mux_7seg_scan_pkg.sv | 23 ++
 rtl/scan_timer_7seg.sv | 56 +++++
 rtl/mux_7seg_scan.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_7seg_scan_pkg.sv
// rtl/mux_7seg_scan_pkg.sv - shared 7-segment definitions for decoder and scan mux
package mux_7seg_scan_pkg;

    // Segment pattern layout {dp,g,f,e,d,c,b,a}, active-high inside the fabric
    localparam int SEG_W    = 8;
    localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    // Apply board pin polarity to an active-high segment pattern
    function automatic logic [SEG_W-1:0] seg_to_pin(input logic [SEG_W-1:0] v,
                                                    input logic             inv);
        return inv ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_timer_7seg.sv
// rtl/scan_timer_7seg.sv - slot prescaler and digit index counter for the scan mux
import mux_7seg_scan_pkg::*;

module scan_timer_7seg #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CW           = 16,
    parameter int IW           = 2
) (
    input  logic          clk,
    input  logic          reset,
    output logic          o_c_first,
    output logic          o_c_last,
    output logic          o_blank,
    output logic [IW-1:0] o_idx,
    output logic          o_frame_wrap
);

    logic [CW-1:0] r_c;
    logic [IW-1:0] r_idx;
    logic          r_frame_wrap;
    logic          w_idx_last;

    assign o_c_first    = (r_c == '0);
    assign o_c_last     = (r_c == CW'(SCAN_DIV - 1));
    assign w_idx_last   = (r_idx == IW'(N_DIGITS - 1));
    assign o_idx        = r_idx;
    assign o_frame_wrap = r_frame_wrap;

    // The leading part of every slot is dark so the previous digit cannot ghost
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign o_blank = 1'b0;
    end else begin : g_blank
        assign o_blank = (r_c < CW'(BLANK_CYCLES));
    end

    // Prescaler wraps each slot; idx steps on the last cycle of a slot.
    // frame_wrap marks the first cycle of slot 0 that follows a full frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c          <= '0;
            r_idx        <= '0;
            r_frame_wrap <= 1'b0;
        end else begin
            r_frame_wrap <= o_c_last && w_idx_last;
            if (o_c_last) begin
                r_c   <= '0;
                r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
            end else begin
                r_c <= r_c + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_7seg_scan.sv
// rtl/mux_7seg_scan.sv - time-multiplexed common-segment 7-seg display driver
import mux_7seg_scan_pkg::*;

module mux_7seg_scan #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEG_W*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]       digit_en,
    output logic [SEG_W-1:0]          segs,
    output logic [N_DIGITS-1:0]       an,
    output logic                      frame_tick
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    if (N_DIGITS < 1) begin : g_bad_n_digits
        $error("mux_7seg_scan: N_DIGITS must be >= 1");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("mux_7seg_scan: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES > SCAN_DIV - 1) begin : g_bad_blank
        $error("mux_7seg_scan: BLANK_CYCLES must be in 0..SCAN_DIV-1");
    end

    logic          w_c_first;
    logic          w_c_last;
    logic          w_blank;
    logic [IW-1:0] w_idx;
    logic          w_frame_wrap;

    scan_timer_7seg #(
        .N_DIGITS     (N_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CW           (CW),
        .IW           (IW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .o_c_first    (w_c_first),
        .o_c_last     (w_c_last),
        .o_blank      (w_blank),
        .o_idx        (w_idx),
        .o_frame_wrap (w_frame_wrap)
    );

    logic [SEG_W-1:0]    r_seg_q;
    logic                r_en_q;
    logic [SEG_W-1:0]    r_segs;
    logic [N_DIGITS-1:0] r_an;
    logic                r_frame_tick;

    logic [SEG_W-1:0]    w_seg_sel;
    logic                w_en_sel;
    logic [SEG_W-1:0]    w_seg_cur;
    logic                w_en_cur;
    logic [SEG_W-1:0]    w_segs_next;
    logic [N_DIGITS-1:0] w_an_next;

    // Pick the current digit's inputs and decide what the pins show next.
    // On the snapshot cycle the value being captured is used directly, so a
    // zero-length blank still hands over cleanly to the new digit.
    always_comb begin
        w_seg_sel   = SEG_OFF;
        w_en_sel    = 1'b0;
        w_an_next   = '0;
        w_segs_next = SEG_OFF;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (w_idx == IW'(d)) begin
                w_seg_sel = seg_in[d*SEG_W +: SEG_W];
                w_en_sel  = digit_en[d];
            end
        end
        w_seg_cur = w_c_first ? w_seg_sel : r_seg_q;
        w_en_cur  = w_c_first ? w_en_sel  : r_en_q;
        if (!w_blank && w_en_cur) begin
            w_segs_next = w_seg_cur;
            for (int d = 0; d < N_DIGITS; d++) begin
                if (w_idx == IW'(d)) begin
                    w_an_next[d] = 1'b1;
                end
            end
        end
    end

    // Snapshot at slot start, then register every output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_q      <= SEG_OFF;
            r_en_q       <= 1'b0;
            r_segs       <= SEG_OFF;
            r_an         <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_c_first) begin
                r_seg_q <= w_seg_sel;
                r_en_q  <= w_en_sel;
            end
            r_segs       <= w_segs_next;
            r_an         <= w_an_next;
            r_frame_tick <= w_frame_wrap;
        end
    end

    assign segs       = seg_to_pin(r_segs, SEG_ACTIVE_LOW != 0);
    assign an         = (AN_ACTIVE_LOW != 0) ? ~r_an : r_an;
    assign frame_tick = r_frame_tick;

endmodule
